// File: rtl/freq_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_capture_pkg
// Description : Shared constants and elaboration-time helpers for the
//               multichannel frequency capture block: register-port opcodes,
//               FSM state encodings, target period / tolerance arithmetic and
//               the band-membership test used by every analyzer channel.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_capture_pkg;

    // Register write port opcodes
    localparam logic [1:0] REGISTER_WRITE_OPERATION = 2'd2;
    localparam logic [1:0] REGISTER_IDLE_OPERATION  = 2'd0;

    // Control FSM state encodings
    localparam logic [1:0] c_state_idle = 2'd0;
    localparam logic [1:0] c_state_run  = 2'd1;
    localparam logic [1:0] c_state_dump = 2'd2;
    localparam logic [1:0] c_state_done = 2'd3;

    // Target period in clocks; a zero frequency yields period 0, which no
    // measured period (always >= 1) can ever match with zero tolerance.
    function automatic logic [63:0] calc_period(input logic [63:0] clock_hz,
                                                input logic [63:0] freq_hz);
        if (freq_hz == 64'd0) begin
            return 64'd0;
        end
        return clock_hz / freq_hz;
    endfunction

    // Allowed absolute deviation in clocks, percent of the target period
    function automatic logic [63:0] calc_tolerance(input logic [63:0] period,
                                                   input logic [63:0] deviation_pct);
        return (period * deviation_pct) / 64'd100;
    endfunction

    // |measured - target| <= tolerance, computed without signed arithmetic
    function automatic logic in_band(input logic [63:0] measured,
                                     input logic [63:0] target,
                                     input logic [63:0] tolerance);
        logic [63:0] diff;
        diff = (measured > target) ? (measured - target) : (target - measured);
        return (diff <= tolerance);
    endfunction

endpackage : freq_capture_pkg
`default_nettype wire

// File: rtl/frequency_band_channel.sv
`default_nettype none
// ============================================================================
// Module      : frequency_band_channel
// Description : One analyzer channel. Measures the period between rising
//               edges of a sampled bit and accumulates every measured period
//               that falls inside either of two target bands.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_enable          - measurement active (state frozen when low)
//               i_clear           - zero counter, accumulators and arm flag
//               i_sample_bit      - sampled pixel bit
//               o_acc0 / o_acc1   - time-in-band accumulators, band 0 / 1
// Revision    : 1.0 - initial release
// ============================================================================
module frequency_band_channel
    import freq_capture_pkg::*;
#(
    parameter int          COUNTER_WIDTH = 32,
    parameter logic [63:0] PERIOD0       = 64'd0,
    parameter logic [63:0] TOLERANCE0    = 64'd0,
    parameter logic [63:0] PERIOD1       = 64'd0,
    parameter logic [63:0] TOLERANCE1    = 64'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enable,
    input  logic                     i_clear,
    input  logic                     i_sample_bit,
    output logic [COUNTER_WIDTH-1:0] o_acc0,
    output logic [COUNTER_WIDTH-1:0] o_acc1
);

    localparam logic [COUNTER_WIDTH-1:0] c_all_ones = '1;

    logic                     r_prev;
    logic                     r_armed;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [COUNTER_WIDTH-1:0] r_acc0;
    logic [COUNTER_WIDTH-1:0] r_acc1;

    logic                     w_rise;
    logic [COUNTER_WIDTH:0]   w_period;
    logic [COUNTER_WIDTH:0]   w_sum0;
    logic [COUNTER_WIDTH:0]   w_sum1;
    logic                     w_match0;
    logic                     w_match1;

    assign w_rise   = i_sample_bit & ~r_prev;
    // One bit wider so a saturated counter still yields a correct period
    assign w_period = {1'b0, r_count} + {{COUNTER_WIDTH{1'b0}}, 1'b1};
    assign w_match0 = in_band(64'(w_period), PERIOD0, TOLERANCE0);
    assign w_match1 = in_band(64'(w_period), PERIOD1, TOLERANCE1);
    // Carry-out of these sums is the saturation flag
    assign w_sum0   = {1'b0, r_acc0} + w_period;
    assign w_sum1   = {1'b0, r_acc1} + w_period;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_count <= '0;
            r_acc0  <= '0;
            r_acc1  <= '0;
        end else if (i_enable) begin
            r_prev <= i_sample_bit;
            if (w_rise) begin
                r_count <= '0;
                r_armed <= 1'b1;
                // The first edge only establishes a reference point
                if (r_armed) begin
                    if (w_match0) begin
                        r_acc0 <= w_sum0[COUNTER_WIDTH] ? c_all_ones : w_sum0[COUNTER_WIDTH-1:0];
                    end
                    if (w_match1) begin
                        r_acc1 <= w_sum1[COUNTER_WIDTH] ? c_all_ones : w_sum1[COUNTER_WIDTH-1:0];
                    end
                end
            end else if (r_count != c_all_ones) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_acc0 = r_acc0;
    assign o_acc1 = r_acc1;

endmodule : frequency_band_channel
`default_nettype wire

// File: rtl/multichannel_frequency_capture.sv
`default_nettype none
// ============================================================================
// Module      : multichannel_frequency_capture
// Description : Samples bit 7 of selected pixels in the pixel stream, measures
//               the period of each sampled bit and accumulates time spent in
//               two frequency bands per channel. On stop, the 2*CHANNELS
//               accumulators are written out over the register write port
//               (register 2i = band 0 of channel i, 2i+1 = band 1), then irq
//               pulses for one cycle.
// Ports       : clock, reset        - clock, synchronous active-high reset
//               pixel_valid/data    - pixel stream, bit 7 sampled
//               line_start          - marks pixel index 0
//               start/stop/clear    - capture control
//               register_operation  - 2 = write request, 0 = idle
//               register_number     - target register index
//               register_write      - write data
//               register_ack        - write accepted this cycle
//               busy/done/irq       - status
// Revision    : 1.0 - initial release
// ============================================================================
module multichannel_frequency_capture
    import freq_capture_pkg::*;
#(
    parameter int                                     CHANNELS            = 3,
    parameter int                                     PIXEL_INDEX_WIDTH   = 10,
    parameter int                                     COUNTER_WIDTH       = 32,
    parameter logic [CHANNELS*PIXEL_INDEX_WIDTH-1:0] PIXEL_INDICES       = {10'd1023, 10'd511, 10'd15},
    parameter logic [CHANNELS*32-1:0]                FREQUENCIES0        = {32'd9000, 32'd9000, 32'd9000},
    parameter logic [CHANNELS*32-1:0]                FREQUENCIES1        = {32'd11000, 32'd11000, 32'd11000},
    parameter int                                     FREQUENCY_DEVIATION = 10,
    parameter int                                     CLOCK_FREQUENCY     = 100000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pixel_valid,
    input  logic [7:0]  pixel_data,
    input  logic        line_start,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    output logic [1:0]  register_operation,
    output logic [7:0]  register_number,
    output logic [31:0] register_write,
    input  logic        register_ack,
    output logic        busy,
    output logic        done,
    output logic        irq
);

    localparam int                  c_regs     = 2 * CHANNELS;
    localparam int                  c_idx_w    = $clog2(c_regs + 1);
    localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(c_regs - 1);
    localparam logic [c_idx_w-1:0]  c_num_regs = c_idx_w'(c_regs);

    logic [1:0]                   r_state;
    logic [PIXEL_INDEX_WIDTH-1:0] r_pixel_count;
    logic [CHANNELS-1:0]          r_sample;
    logic [c_idx_w-1:0]           r_index;

    logic                         w_run;
    logic                         w_meas_clear;
    logic                         w_chan_enable;
    logic [PIXEL_INDEX_WIDTH-1:0] w_pixel_index;
    logic [c_idx_w-1:0]           w_dump_sel;
    logic [COUNTER_WIDTH-1:0]     w_acc [0:c_regs-1];
    logic [COUNTER_WIDTH-1:0]     w_sel_acc;
    logic [31:0]                  w_word;
    logic                         w_unused_pixel_bits;

    assign w_unused_pixel_bits = ^pixel_data[6:0];

    assign w_run = (r_state == c_state_run);
    // Every entry into RUN starts from a clean slate, as does clear in RUN.
    // Stop takes priority over clear so the dumped values are the final ones.
    assign w_meas_clear = (((r_state == c_state_idle) || (r_state == c_state_done)) && start)
                        || (w_run && clear && !stop);
    // Freeze measurement on the stop cycle so the first dump word is exact
    assign w_chan_enable = w_run && !stop;

    // A pixel flagged with line_start is index 0 regardless of the counter
    assign w_pixel_index = line_start ? '0 : r_pixel_count;

    // Pixel counter and sample latches
    always_ff @(posedge clock) begin
        if (reset || w_meas_clear) begin
            r_pixel_count <= '0;
            r_sample      <= '0;
        end else if (w_chan_enable) begin
            if (pixel_valid) begin
                r_pixel_count <= line_start ? PIXEL_INDEX_WIDTH'(1) : r_pixel_count + 1'b1;
            end else if (line_start) begin
                r_pixel_count <= '0;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (pixel_valid && (w_pixel_index == PIXEL_INDICES[i*PIXEL_INDEX_WIDTH +: PIXEL_INDEX_WIDTH])) begin
                    r_sample[i] <= pixel_data[7];
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
        localparam logic [63:0] c_period0 = calc_period(64'(CLOCK_FREQUENCY), 64'(FREQUENCIES0[g*32 +: 32]));
        localparam logic [63:0] c_period1 = calc_period(64'(CLOCK_FREQUENCY), 64'(FREQUENCIES1[g*32 +: 32]));

        frequency_band_channel #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .PERIOD0       (c_period0),
            .TOLERANCE0    (calc_tolerance(c_period0, 64'(FREQUENCY_DEVIATION))),
            .PERIOD1       (c_period1),
            .TOLERANCE1    (calc_tolerance(c_period1, 64'(FREQUENCY_DEVIATION)))
        ) u_channel (
            .clk          (clock),
            .rst          (reset),
            .i_enable     (w_chan_enable),
            .i_clear      (w_meas_clear),
            .i_sample_bit (r_sample[g]),
            .o_acc0       (w_acc[2*g]),
            .o_acc1       (w_acc[2*g+1])
        );
    end

    // Word to load next: register 0 when leaving RUN, else the one after r_index
    assign w_dump_sel = w_run ? '0 : (r_index + 1'b1);
    assign w_sel_acc  = (w_dump_sel < c_num_regs) ? w_acc[w_dump_sel] : '0;

    if (COUNTER_WIDTH >= 32) begin : g_word_truncate
        assign w_word = w_sel_acc[31:0];
    end else begin : g_word_extend
        assign w_word = {{(32-COUNTER_WIDTH){1'b0}}, w_sel_acc};
    end

    // Control FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state            <= c_state_idle;
            r_index            <= '0;
            register_operation <= REGISTER_IDLE_OPERATION;
            register_number    <= 8'd0;
            register_write     <= 32'd0;
            busy               <= 1'b0;
            done               <= 1'b0;
            irq                <= 1'b0;
        end else begin
            irq <= 1'b0;
            case (r_state)
                c_state_idle: begin
                    if (start) begin
                        r_state <= c_state_run;
                        busy    <= 1'b1;
                    end
                end
                c_state_run: begin
                    if (stop) begin
                        r_state            <= c_state_dump;
                        r_index            <= '0;
                        register_operation <= REGISTER_WRITE_OPERATION;
                        register_number    <= 8'd0;
                        register_write     <= w_word;
                    end
                end
                c_state_dump: begin
                    if (register_ack && (register_operation == REGISTER_WRITE_OPERATION)) begin
                        if (r_index == c_last_idx) begin
                            r_state            <= c_state_done;
                            register_operation <= REGISTER_IDLE_OPERATION;
                            busy               <= 1'b0;
                            done               <= 1'b1;
                            irq                <= 1'b1;
                        end else begin
                            // Next request is presented the cycle after the ack
                            r_index         <= r_index + 1'b1;
                            register_number <= 8'(r_index + 1'b1);
                            register_write  <= w_word;
                        end
                    end
                end
                c_state_done: begin
                    if (start) begin
                        r_state <= c_state_run;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else if (clear) begin
                        r_state <= c_state_idle;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_state_idle;
                end
            endcase
        end
    end

endmodule : multichannel_frequency_capture
`default_nettype wire

// File: tb/tb_multichannel_frequency_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_multichannel_frequency_capture
// Description : Directed self-checking bench for multichannel_frequency_capture
//               with 3 channels on pixel indices 0/1/2 of a 4-pixel line,
//               1 MHz clock, bands 1000 Hz (P=1000) and 500 Hz (P=2000), 10 %.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multichannel_frequency_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic        pixel_valid;
    logic [7:0]  pixel_data;
    logic        line_start;
    logic        start;
    logic        stop;
    logic        clear;
    logic [1:0]  register_operation;
    logic [7:0]  register_number;
    logic [31:0] register_write;
    logic        register_ack;
    logic        busy;
    logic        done;
    logic        irq;

    int          n_total = 0;
    int          n_bad   = 0;
    int          irq_count = 0;
    logic [31:0] exp_regs [6];

    int          wv_per   [3];
    int          wv_edges [3];
    int          wv_t     [3];
    int          tb_idx;

    multichannel_frequency_capture #(
        .CHANNELS            (3),
        .PIXEL_INDEX_WIDTH   (2),
        .COUNTER_WIDTH       (32),
        .PIXEL_INDICES       ({2'd2, 2'd1, 2'd0}),
        .FREQUENCIES0        ({32'd1000, 32'd1000, 32'd1000}),
        .FREQUENCIES1        ({32'd500, 32'd500, 32'd500}),
        .FREQUENCY_DEVIATION (10),
        .CLOCK_FREQUENCY     (1000000)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .pixel_valid        (pixel_valid),
        .pixel_data         (pixel_data),
        .line_start         (line_start),
        .start              (start),
        .stop               (stop),
        .clear              (clear),
        .register_operation (register_operation),
        .register_number    (register_number),
        .register_write     (register_write),
        .register_ack       (register_ack),
        .busy               (busy),
        .done               (done),
        .irq                (irq)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Square wave: rising at t = 0, per, ..., (edges-1)*per, high for per/2
    function automatic logic wave_level(input int ch);
        return (wv_edges[ch] > 0) && ((wv_t[ch] % wv_per[ch]) < (wv_per[ch] / 2))
               && ((wv_t[ch] / wv_per[ch]) < wv_edges[ch]);
    endfunction

    task automatic set_wave(input int ch, input int per, input int edges);
        wv_per[ch]   = per;
        wv_edges[ch] = edges;
        wv_t[ch]     = 0;
    endtask

    // Pixel stream: 4-pixel lines, pixel k carries channel k's wave on bit 7
    initial begin
        for (int i = 0; i < 3; i++) begin
            wv_per[i] = 4; wv_edges[i] = 0; wv_t[i] = 0;
        end
        tb_idx      = 0;
        pixel_valid = 1'b1;
        pixel_data  = 8'd0;
        line_start  = 1'b0;
        forever begin
            @(negedge clock);
            line_start = (tb_idx == 0);
            pixel_data = 8'd0;
            if (tb_idx < 3) pixel_data[7] = wave_level(tb_idx);
            for (int i = 0; i < 3; i++) wv_t[i]++;
            tb_idx = (tb_idx + 1) % 4;
        end
    end

    initial forever begin
        @(posedge clock);
        if (irq === 1'b1) irq_count++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_request();
        int c;
        c = 0;
        while (register_operation != 2'd2 && c < 64) begin
            @(negedge clock);
            c++;
        end
    endtask

    task automatic run_dump(input int delay);
        logic [31:0] held_num;
        logic [31:0] held_data;
        int          irq_before;
        irq_before = irq_count;
        for (int k = 0; k < 6; k++) begin
            wait_request();
            chk("req_op", 32'(register_operation), 32'd2);
            chk("req_num", 32'(register_number), 32'(k));
            chk("req_data", register_write, exp_regs[k]);
            chk("req_irq", 32'(irq), 32'd0);
            held_num  = 32'(register_number);
            held_data = register_write;
            for (int d = 0; d < delay; d++) begin
                @(negedge clock);
                chk("hold_op", 32'(register_operation), 32'd2);
                chk("hold_num", 32'(register_number), held_num);
                chk("hold_data", register_write, held_data);
            end
            register_ack = 1'b1;
            @(negedge clock);
            register_ack = 1'b0;
        end
        chk("end_op", 32'(register_operation), 32'd0);
        chk("end_irq", 32'(irq), 32'd1);
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        @(negedge clock);
        chk("irq_one_cycle", 32'(irq), 32'd0);
        wait_cycles(8);
        chk("no_extra_write", 32'(register_operation), 32'd0);
        chk("irq_count", 32'(irq_count - irq_before), 32'd1);
        chk("done_held", 32'(done), 32'd1);
    endtask

    task automatic set_exp(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] r3, input logic [31:0] r4, input logic [31:0] r5);
        exp_regs[0] = r0; exp_regs[1] = r1; exp_regs[2] = r2;
        exp_regs[3] = r3; exp_regs[4] = r4; exp_regs[5] = r5;
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clock); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clock); stop = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int irq_before;
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; register_ack = 1'b0;
        wait_cycles(4);
        chk("rst_op", 32'(register_operation), 32'd0);
        chk("rst_num", 32'(register_number), 32'd0);
        chk("rst_data", register_write, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        wait_cycles(2);

        // Stop alone in IDLE is ignored
        pulse_stop();
        wait_cycles(10);
        chk("idle_stop_op", 32'(register_operation), 32'd0);
        chk("idle_stop_busy", 32'(busy), 32'd0);

        // T1: ch0 period 1000, 11 edges -> 10 periods in band 0
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        wait_cycles(10);
        set_wave(0, 1000, 11);
        wait_cycles(11600);
        pulse_stop();
        set_exp(32'd10000, 0, 0, 0, 0, 0);
        run_dump(1);

        // T2: ch1 period 2000 x5 (band 1), ch2 period 1080 x3 (band 0)
        pulse_start();
        chk("t2_done_cleared", 32'(done), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        wait_cycles(10);
        set_wave(1, 2000, 5);
        set_wave(2, 1080, 3);
        wait_cycles(10600);
        pulse_stop();
        set_exp(0, 0, 0, 32'd8000, 32'd2160, 0);
        run_dump(1);

        // T2b: ch2 period 1120 is outside both bands
        pulse_start();
        wait_cycles(10);
        set_wave(2, 1120, 3);
        wait_cycles(3600);
        pulse_stop();
        set_exp(0, 0, 0, 0, 0, 0);
        run_dump(1);

        // T3: slow acknowledger, 7 cycles per write
        pulse_start();
        wait_cycles(10);
        set_wave(0, 1000, 3);
        wait_cycles(3600);
        pulse_stop();
        set_exp(32'd2000, 0, 0, 0, 0, 0);
        run_dump(7);

        // T4: clear after 5 periods; of 3 later edges the first only arms
        pulse_start();
        wait_cycles(10);
        set_wave(0, 1000, 9);
        wait_cycles(5700);
        clear = 1'b1; @(negedge clock); clear = 1'b0;
        wait_cycles(3600);
        pulse_stop();
        set_exp(32'd2000, 0, 0, 0, 0, 0);
        run_dump(1);

        // T5: reset during the third dump write
        pulse_start();
        wait_cycles(10);
        set_wave(0, 1000, 3);
        wait_cycles(3600);
        pulse_stop();
        irq_before = irq_count;
        for (int k = 0; k < 2; k++) begin
            wait_request();
            register_ack = 1'b1; @(negedge clock); register_ack = 1'b0;
        end
        wait_request();
        chk("t5_third_num", 32'(register_number), 32'd2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t5_op", 32'(register_operation), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        wait_cycles(10);
        chk("t5_no_irq", 32'(irq_count - irq_before), 32'd0);

        // T6: start and stop together in IDLE -> start wins, no dump yet
        start = 1'b1; stop = 1'b1;
        @(negedge clock);
        start = 1'b0; stop = 1'b0;
        chk("t6_busy", 32'(busy), 32'd1);
        wait_cycles(3);
        chk("t6_no_write", 32'(register_operation), 32'd0);
        wait_cycles(10);
        pulse_stop();
        set_exp(0, 0, 0, 0, 0, 0);
        run_dump(1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_multichannel_frequency_capture
`default_nettype wire
